// File: rtl/rcv_ctrl_pkg.sv
// rcv_ctrl_pkg
// Shared definitions for the UART receive controller: drain FSM state
// encoding, reset defaults for the receiver configuration and the bounds
// that decide whether a host configuration write is accepted.
package rcv_ctrl_pkg;

    typedef enum logic [1:0] {
        DRAIN_IDLE     = 2'd0,
        DRAIN_ACK      = 2'd1,
        DRAIN_WAIT_CLR = 2'd2
    } drain_state_e;

    localparam logic [3:0]  DEF_DATA_SIZE  = 4'd8;
    localparam logic [13:0] DEF_BIT_PERIOD = 14'd10;

    localparam logic [3:0]  MIN_DATA_SIZE  = 4'd5;
    localparam logic [3:0]  MAX_DATA_SIZE  = 4'd8;
    localparam logic [13:0] MIN_BIT_PERIOD = 14'd2;

    // A configuration is usable by the receiver only with a data size the
    // shifter supports and a bit period long enough for the timer to run.
    function automatic logic cfg_is_legal(input logic [3:0]  size,
                                          input logic [13:0] period);
        return (size >= MIN_DATA_SIZE) && (size <= MAX_DATA_SIZE) &&
               (period >= MIN_BIT_PERIOD);
    endfunction

endpackage

// File: rtl/rx_fifo4.sv
// rx_fifo4
// 8-bit x 4 show-ahead FIFO holding received bytes until the host pops them.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   push/push_data write one byte (ignored when full)
//   pop            drop the head entry (ignored when empty)
//   rd_data        head entry, 0 while empty
//   empty/full     occupancy flags decoded from the count
//   count          occupancy 0..4
module rx_fifo4 #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] rd_data,
    output logic       empty,
    output logic       full,
    output logic [2:0] count
);

    logic [7:0] mem_q [4];
    logic [7:0] mem_d [4];
    logic [1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0] rd_ptr_q, rd_ptr_d;
    logic [2:0] count_q, count_d;
    logic       do_push, do_pop;

    assign empty   = (count_q == 3'd0);
    assign full    = (count_q == 3'(DEPTH));
    assign count   = count_q;
    // Gate the head with empty so stale bytes never show after draining.
    assign rd_data = empty ? 8'd0 : mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            // 2-bit pointers wrap 3->0 on their own.
            wr_ptr_d = wr_ptr_q + 2'd1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= 8'd0;
            end
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/rcv_ctrl.sv
// rcv_ctrl
// Controller for the UART receive block. Holds the receiver configuration
// and only applies host changes between packets, drains received bytes into
// a 4-entry show-ahead FIFO through the data_ready/data_read handshake, and
// keeps sticky error status for the host.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   cfg_wr/cfg_data_size/cfg_bit_period  host configuration write
//   cfg_pending, cfg_err             write accepted-not-applied / rejected pulse
//   rcv_busy                         receiver mid-packet
//   data_size, bit_period            active configuration to the receiver
//   rx_data, data_ready, data_read   receiver byte handshake
//   overrun_error, framing_error     receiver error strobes
//   pop, rd_data, fifo_*             host side of the FIFO
//   err_overrun, err_framing, status_clr  sticky error status
module rcv_ctrl
    import rcv_ctrl_pkg::*;
#(
    parameter int          FIFO_DEPTH     = 4,
    parameter logic [3:0]  RST_DATA_SIZE  = DEF_DATA_SIZE,
    parameter logic [13:0] RST_BIT_PERIOD = DEF_BIT_PERIOD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_wr,
    input  logic [3:0]  cfg_data_size,
    input  logic [13:0] cfg_bit_period,
    output logic        cfg_pending,
    output logic        cfg_err,
    input  logic        rcv_busy,
    output logic [3:0]  data_size,
    output logic [13:0] bit_period,
    input  logic [7:0]  rx_data,
    input  logic        data_ready,
    input  logic        overrun_error,
    input  logic        framing_error,
    output logic        data_read,
    input  logic        pop,
    output logic [7:0]  rd_data,
    output logic        fifo_empty,
    output logic        fifo_full,
    output logic [2:0]  fifo_count,
    output logic        err_overrun,
    output logic        err_framing,
    input  logic        status_clr
);

    logic [3:0]   shadow_size_q, shadow_size_d;
    logic [13:0]  shadow_period_q, shadow_period_d;
    logic [3:0]   data_size_q, data_size_d;
    logic [13:0]  bit_period_q, bit_period_d;
    logic         cfg_pending_q, cfg_pending_d;
    logic         cfg_err_q, cfg_err_d;
    logic         err_overrun_q, err_overrun_d;
    logic         err_framing_q, err_framing_d;
    drain_state_e state_q, state_d;
    logic         data_read_q, data_read_d;
    logic         cfg_legal;
    logic         fifo_push;

    assign cfg_pending = cfg_pending_q;
    assign cfg_err     = cfg_err_q;
    assign data_size   = data_size_q;
    assign bit_period  = bit_period_q;
    assign data_read   = data_read_q;
    assign err_overrun = err_overrun_q;
    assign err_framing = err_framing_q;
    assign fifo_push   = (state_q == DRAIN_ACK);

    rx_fifo4 #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (rx_data),
        .pop       (pop),
        .rd_data   (rd_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    // Configuration and sticky errors. The apply is evaluated before the
    // write so that a write landing in the apply cycle refills the shadow
    // and keeps cfg_pending set for the next gap between packets.
    always_comb begin
        cfg_legal       = cfg_is_legal(cfg_data_size, cfg_bit_period);
        shadow_size_d   = shadow_size_q;
        shadow_period_d = shadow_period_q;
        data_size_d     = data_size_q;
        bit_period_d    = bit_period_q;
        cfg_pending_d   = cfg_pending_q;
        cfg_err_d       = cfg_wr && !cfg_legal;
        if (cfg_pending_q && !rcv_busy) begin
            data_size_d   = shadow_size_q;
            bit_period_d  = shadow_period_q;
            cfg_pending_d = 1'b0;
        end
        if (cfg_wr && cfg_legal) begin
            shadow_size_d   = cfg_data_size;
            shadow_period_d = cfg_bit_period;
            cfg_pending_d   = 1'b1;
        end
        // Set wins over clear so an error in the clearing cycle is kept.
        err_overrun_d = overrun_error || (err_overrun_q && !status_clr);
        err_framing_d = framing_error || (err_framing_q && !status_clr);
    end

    // Drain FSM. data_read is registered and high exactly in the ACK cycle,
    // which is also the cycle the byte is pushed. WAIT_CLR holds off until
    // the receiver drops data_ready so one byte is never pushed twice.
    always_comb begin
        state_d     = state_q;
        data_read_d = 1'b0;
        case (state_q)
            DRAIN_IDLE: begin
                if (data_ready && !fifo_full) begin
                    state_d     = DRAIN_ACK;
                    data_read_d = 1'b1;
                end
            end
            DRAIN_ACK: begin
                state_d = DRAIN_WAIT_CLR;
            end
            DRAIN_WAIT_CLR: begin
                if (!data_ready) begin
                    state_d = DRAIN_IDLE;
                end
            end
            default: begin
                state_d = DRAIN_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= DRAIN_IDLE;
            data_read_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_read_q <= data_read_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_size_q   <= RST_DATA_SIZE;
            shadow_period_q <= RST_BIT_PERIOD;
            data_size_q     <= RST_DATA_SIZE;
            bit_period_q    <= RST_BIT_PERIOD;
            cfg_pending_q   <= 1'b0;
            cfg_err_q       <= 1'b0;
            err_overrun_q   <= 1'b0;
            err_framing_q   <= 1'b0;
        end else begin
            shadow_size_q   <= shadow_size_d;
            shadow_period_q <= shadow_period_d;
            data_size_q     <= data_size_d;
            bit_period_q    <= bit_period_d;
            cfg_pending_q   <= cfg_pending_d;
            cfg_err_q       <= cfg_err_d;
            err_overrun_q   <= err_overrun_d;
            err_framing_q   <= err_framing_d;
        end
    end

endmodule

// File: tb/tb_rcv_ctrl.sv
// tb_rcv_ctrl
// Self-checking bench for rcv_ctrl. The reference keeps the FIFO as a byte
// queue and the configuration as plain expected values derived from the
// accept/apply rules; receiver bytes are driven as full handshakes.
module tb_rcv_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_wr;
    logic [3:0]  cfg_data_size;
    logic [13:0] cfg_bit_period;
    logic        cfg_pending;
    logic        cfg_err;
    logic        rcv_busy;
    logic [3:0]  data_size;
    logic [13:0] bit_period;
    logic [7:0]  rx_data;
    logic        data_ready;
    logic        overrun_error;
    logic        framing_error;
    logic        data_read;
    logic        pop;
    logic [7:0]  rd_data;
    logic        fifo_empty;
    logic        fifo_full;
    logic [2:0]  fifo_count;
    logic        err_overrun;
    logic        err_framing;
    logic        status_clr;

    int compares = 0;
    int mismatches = 0;
    int read_pulses = 0;
    int expected_pulses = 0;

    logic [7:0]  model_q[$];
    logic [3:0]  exp_size;
    logic [13:0] exp_period;
    logic        exp_ov;
    logic        exp_fr;

    rcv_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_wr         (cfg_wr),
        .cfg_data_size  (cfg_data_size),
        .cfg_bit_period (cfg_bit_period),
        .cfg_pending    (cfg_pending),
        .cfg_err        (cfg_err),
        .rcv_busy       (rcv_busy),
        .data_size      (data_size),
        .bit_period     (bit_period),
        .rx_data        (rx_data),
        .data_ready     (data_ready),
        .overrun_error  (overrun_error),
        .framing_error  (framing_error),
        .data_read      (data_read),
        .pop            (pop),
        .rd_data        (rd_data),
        .fifo_empty     (fifo_empty),
        .fifo_full      (fifo_full),
        .fifo_count     (fifo_count),
        .err_overrun    (err_overrun),
        .err_framing    (err_framing),
        .status_clr     (status_clr)
    );

    always #5 clk = ~clk;

    // Every acknowledge the receiver sees, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst && data_read) read_pulses++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compares++;
        assert (observed === expected) else begin
            mismatches++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus();
        cfg_wr = 1'b0; cfg_data_size = 4'd0; cfg_bit_period = 14'd0;
        rcv_busy = 1'b0; rx_data = 8'd0; data_ready = 1'b0;
        overrun_error = 1'b0; framing_error = 1'b0; pop = 1'b0; status_clr = 1'b0;
    endtask

    function automatic logic is_legal(input logic [3:0] s, input logic [13:0] p);
        return (s >= 4'd5) && (s <= 4'd8) && (p >= 14'd2);
    endfunction

    task automatic checkFifo(input string tag);
        logic [7:0] head;
        head = (model_q.size() > 0) ? model_q[0] : 8'd0;
        checkOutput({tag, " count"}, fifo_count, model_q.size());
        checkOutput({tag, " empty"}, fifo_empty, model_q.size() == 0);
        checkOutput({tag, " full"},  fifo_full,  model_q.size() == 4);
        checkOutput({tag, " rd_data"}, rd_data, head);
    endtask

    task automatic checkCfg(input string tag);
        checkOutput({tag, " data_size"},  data_size,  exp_size);
        checkOutput({tag, " bit_period"}, bit_period, exp_period);
    endtask

    // One byte through the receiver handshake; FIFO must have room.
    task automatic sendByte(input logic [7:0] b);
        rx_data = b;
        data_ready = 1'b1;
        tick();
        checkOutput("data_read latency", data_read, 1'b1);
        data_ready = 1'b0;
        model_q.push_back(b);
        expected_pulses++;
        tick();
        checkOutput("data_read single", data_read, 1'b0);
        tick();
        checkFifo("after push");
    endtask

    task automatic popByte();
        pop = 1'b1;
        tick();
        pop = 1'b0;
        if (model_q.size() > 0) void'(model_q.pop_front());
        checkFifo("after pop");
    endtask

    task automatic cfgWrite(input logic [3:0] s, input logic [13:0] p);
        cfg_wr = 1'b1;
        cfg_data_size = s;
        cfg_bit_period = p;
        tick();
        cfg_wr = 1'b0;
    endtask

    initial begin
        int got;
        logic [3:0]  rs;
        logic [13:0] rp;
        logic        ov, fr, clr;

        applyStimulus();
        rst = 1'b1;
        exp_size = 4'd8;
        exp_period = 14'd10;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset data_read async", data_read, 1'b0);
        rst = 1'b0;
        checkCfg("reset");
        checkOutput("reset cfg_pending", cfg_pending, 1'b0);
        checkOutput("reset cfg_err", cfg_err, 1'b0);
        checkOutput("reset err_overrun", err_overrun, 1'b0);
        checkOutput("reset err_framing", err_framing, 1'b0);
        checkFifo("reset");
        tick();
        checkOutput("idle data_read", data_read, 1'b0);

        // Write held off while the receiver is busy, illegal writes ignored.
        rcv_busy = 1'b1;
        cfgWrite(4'd7, 14'd100);
        checkOutput("busy pending", cfg_pending, 1'b1);
        for (int i = 0; i < 20; i++) begin
            tick();
            checkOutput("busy hold pending", cfg_pending, 1'b1);
            checkCfg("busy hold");
        end
        cfgWrite(4'd9, 14'd100);
        checkOutput("size 9 cfg_err", cfg_err, 1'b1);
        cfgWrite(4'd7, 14'd1);
        checkOutput("period 1 cfg_err", cfg_err, 1'b1);
        tick();
        checkOutput("cfg_err one cycle", cfg_err, 1'b0);
        rcv_busy = 1'b0;
        tick();
        exp_size = 4'd7;
        exp_period = 14'd100;
        checkCfg("apply after busy");
        checkOutput("apply pending clr", cfg_pending, 1'b0);

        cfgWrite(4'd9, 14'd50);
        checkOutput("idle size 9 cfg_err", cfg_err, 1'b1);
        checkOutput("idle size 9 pending", cfg_pending, 1'b0);
        tick();
        checkOutput("idle cfg_err drop", cfg_err, 1'b0);
        checkCfg("illegal unchanged");

        // Legal write in the same cycle as an apply.
        rcv_busy = 1'b1;
        cfgWrite(4'd6, 14'd50);
        rcv_busy = 1'b0;
        cfgWrite(4'd5, 14'd2000);
        exp_size = 4'd6;
        exp_period = 14'd50;
        checkCfg("simul apply first");
        checkOutput("simul pending kept", cfg_pending, 1'b1);
        tick();
        exp_size = 4'd5;
        exp_period = 14'd2000;
        checkCfg("simul apply second");
        checkOutput("simul pending clr", cfg_pending, 1'b0);

        // Random writes with the receiver idle: N+1 pending, N+2 applied.
        for (int i = 0; i < 12; i++) begin
            rs = 4'($urandom_range(3, 10));
            rp = ($urandom_range(0, 3) == 0) ? 14'($urandom_range(0, 3))
                                              : 14'($urandom_range(0, 16383));
            cfgWrite(rs, rp);
            checkOutput("rand cfg_err", cfg_err, !is_legal(rs, rp));
            checkOutput("rand pending", cfg_pending, is_legal(rs, rp));
            tick();
            if (is_legal(rs, rp)) begin
                exp_size = rs;
                exp_period = rp;
            end
            checkCfg("rand apply");
            checkOutput("rand pending clr", cfg_pending, 1'b0);
        end

        // Directed fill to full, fifth byte held off, errors while full.
        sendByte(8'hA5);
        sendByte(8'h3C);
        sendByte(8'h00);
        sendByte(8'hFF);
        rx_data = 8'h5A;
        data_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("full no ack", data_read, 1'b0);
        end
        overrun_error = 1'b1;
        tick();
        overrun_error = 1'b0;
        checkOutput("overrun set", err_overrun, 1'b1);
        overrun_error = 1'b1;
        status_clr = 1'b1;
        tick();
        checkOutput("overrun set beats clr", err_overrun, 1'b1);
        overrun_error = 1'b0;
        tick();
        status_clr = 1'b0;
        checkOutput("overrun cleared", err_overrun, 1'b0);

        popByte();
        checkOutput("no ack in pop cycle", data_read, 1'b0);
        got = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (data_read) begin
                got = 1;
                break;
            end
        end
        checkOutput("fifth byte ack", got, 1);
        data_ready = 1'b0;
        model_q.push_back(8'h5A);
        expected_pulses++;
        tick();
        tick();
        checkFifo("fifth byte");
        for (int i = 0; i < 4; i++) popByte();
        popByte();

        // Random push/pop mix including pops on empty.
        for (int i = 0; i < 40; i++) begin
            if (model_q.size() < 4 && $urandom_range(0, 1) == 1) sendByte(8'($urandom));
            else popByte();
        end
        checkOutput("one ack per byte", read_pulses, expected_pulses);

        // Random sticky error traffic.
        exp_ov = err_overrun;
        exp_fr = err_framing;
        status_clr = 1'b1;
        tick();
        exp_ov = 1'b0;
        exp_fr = 1'b0;
        for (int i = 0; i < 12; i++) begin
            ov = 1'($urandom_range(0, 1));
            fr = 1'($urandom_range(0, 1));
            clr = 1'($urandom_range(0, 1));
            overrun_error = ov;
            framing_error = fr;
            status_clr = clr;
            tick();
            exp_ov = ov || (exp_ov && !clr);
            exp_fr = fr || (exp_fr && !clr);
            checkOutput("rand err_overrun", err_overrun, exp_ov);
            checkOutput("rand err_framing", err_framing, exp_fr);
        end
        applyStimulus();

        // Push and pop in the same cycle at count 2.
        while (model_q.size() > 0) popByte();
        sendByte(8'h11);
        sendByte(8'h22);
        rx_data = 8'h33;
        data_ready = 1'b1;
        tick();
        checkOutput("ack before simul", data_read, 1'b1);
        expected_pulses++;
        pop = 1'b1;
        data_ready = 1'b0;
        tick();
        pop = 1'b0;
        void'(model_q.pop_front());
        model_q.push_back(8'h33);
        checkFifo("push pop same cycle");
        tick();

        // Asynchronous reset in the middle of an ACK.
        checkOutput("pulse total", read_pulses, expected_pulses);
        rx_data = 8'h44;
        data_ready = 1'b1;
        tick();
        checkOutput("ack before reset", data_read, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        model_q.delete();
        exp_size = 4'd8;
        exp_period = 14'd10;
        checkOutput("reset drops data_read", data_read, 1'b0);
        checkFifo("mid-ack reset");
        checkCfg("mid-ack reset");
        data_ready = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        sendByte(8'h77);
        checkOutput("post reset pulses", read_pulses, expected_pulses);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
        $finish;
    end

endmodule
